// File: rtl/width_adapt_if.sv
// Handshake bundle for the width adaptation stage.
// The slave modport is the stage's view; the master modport is the surrounding logic's view.
`timescale 1ns/1ps
interface width_adapt_if #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32,
    parameter int CNT_W = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  in_data;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_data;
    logic             out_trunc;
    logic [CNT_W-1:0] trunc_count;

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_trunc, trunc_count
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_trunc, trunc_count
    );
endinterface

// File: rtl/width_adapt_stage.sv
// Registered IN_W -> OUT_W width adapter behind a 2-entry skid buffer.
// Words are resized at capture; words that lose information are flagged and counted.
`timescale 1ns/1ps
module width_adapt_stage #(
    parameter int IN_W   = 16,
    parameter int OUT_W  = 32,
    parameter int SIGNED = 0,
    parameter int CNT_W  = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    width_adapt_if.slave   bus
);
    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_FULL  = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_state_next;
    logic [1:0][OUT_W-1:0]   r_data;
    logic [1:0]              r_trunc;
    logic [CNT_W-1:0]        r_count;

    logic [OUT_W-1:0]        w_conv_data;
    logic                    w_conv_trunc;
    logic                    w_accept;
    logic                    w_deliver;
    logic                    w_load_head;
    logic                    w_load_tail;
    logic                    w_shift;

    // Resize the incoming word; the truncation flag only exists when bits are dropped.
    generate
        if (OUT_W > IN_W) begin : g_widen
            if (SIGNED != 0) begin : g_sext
                assign w_conv_data = {{(OUT_W-IN_W){bus.in_data[IN_W-1]}}, bus.in_data};
            end else begin : g_zext
                assign w_conv_data = {{(OUT_W-IN_W){1'b0}}, bus.in_data};
            end
            assign w_conv_trunc = 1'b0;
        end else if (OUT_W == IN_W) begin : g_same
            assign w_conv_data  = bus.in_data;
            assign w_conv_trunc = 1'b0;
        end else begin : g_narrow
            assign w_conv_data = bus.in_data[OUT_W-1:0];
            if (SIGNED != 0) begin : g_strunc
                assign w_conv_trunc = (bus.in_data[IN_W-1:OUT_W] !=
                                       {(IN_W-OUT_W){bus.in_data[OUT_W-1]}});
            end else begin : g_utrunc
                assign w_conv_trunc = |bus.in_data[IN_W-1:OUT_W];
            end
        end
    endgenerate

    assign w_accept  = bus.in_valid  & (r_state != S_FULL);
    assign w_deliver = bus.out_ready & (r_state != S_EMPTY);

    always_comb begin
        w_state_next = r_state;
        w_load_head  = 1'b0;
        w_load_tail  = 1'b0;
        w_shift      = 1'b0;
        case (r_state)
            S_EMPTY: begin
                if (w_accept) begin
                    w_state_next = S_ONE;
                    w_load_head  = 1'b1;
                end
            end
            S_ONE: begin
                // With accept and deliver together the new word replaces the departing head.
                if (w_accept && w_deliver) begin
                    w_load_head  = 1'b1;
                end else if (w_accept) begin
                    w_state_next = S_FULL;
                    w_load_tail  = 1'b1;
                end else if (w_deliver) begin
                    w_state_next = S_EMPTY;
                end
            end
            S_FULL: begin
                if (w_deliver) begin
                    w_state_next = S_ONE;
                    w_shift      = 1'b1;
                end
            end
            default: w_state_next = S_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_EMPTY;
            r_data  <= '0;
            r_trunc <= '0;
            r_count <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_load_head) begin
                r_data[0]  <= w_conv_data;
                r_trunc[0] <= w_conv_trunc;
            end else if (w_shift) begin
                r_data[0]  <= r_data[1];
                r_trunc[0] <= r_trunc[1];
            end
            if (w_load_tail) begin
                r_data[1]  <= w_conv_data;
                r_trunc[1] <= w_conv_trunc;
            end
            if (w_deliver && r_trunc[0] && (r_count != {CNT_W{1'b1}})) begin
                r_count <= r_count + 1'b1;
            end
        end
    end

    assign bus.in_ready    = (r_state != S_FULL);
    assign bus.out_valid   = (r_state != S_EMPTY);
    assign bus.out_data    = r_data[0];
    assign bus.out_trunc   = r_trunc[0];
    assign bus.trunc_count = r_count;
endmodule

// File: tb/tb_width_adapt_stage.sv
// Four stage variants driven with one shared stimulus stream; a queue-based scoreboard
// holds the expected resized words and a negedge monitor compares what each variant presents.
`timescale 1ns/1ps
module tb_width_adapt_stage;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // 0: 16->32 unsigned, 1: 16->32 signed, 2: 16->8 unsigned (2-bit count), 3: 16->8 signed
    width_adapt_if #(.IN_W(16), .OUT_W(32), .CNT_W(16)) if0 ();
    width_adapt_if #(.IN_W(16), .OUT_W(32), .CNT_W(16)) if1 ();
    width_adapt_if #(.IN_W(16), .OUT_W(8),  .CNT_W(2))  if2 ();
    width_adapt_if #(.IN_W(16), .OUT_W(8),  .CNT_W(16)) if3 ();

    width_adapt_stage #(.IN_W(16), .OUT_W(32), .SIGNED(0), .CNT_W(16)) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
    width_adapt_stage #(.IN_W(16), .OUT_W(32), .SIGNED(1), .CNT_W(16)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));
    width_adapt_stage #(.IN_W(16), .OUT_W(8),  .SIGNED(0), .CNT_W(2))  u_dut2 (.clk(clk), .rst_n(rst_n), .bus(if2));
    width_adapt_stage #(.IN_W(16), .OUT_W(8),  .SIGNED(1), .CNT_W(16)) u_dut3 (.clk(clk), .rst_n(rst_n), .bus(if3));

    typedef struct packed {
        logic [3:0][31:0] d;
        logic [3:0]       t;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    logic [31:0] m_data [4];
    logic [31:0] m_cnt  [4];
    logic        m_valid[4];
    logic        m_trunc[4];
    logic        m_rdy  [4];

    assign m_data[0] = if0.out_data;
    assign m_data[1] = if1.out_data;
    assign m_data[2] = {24'h0, if2.out_data};
    assign m_data[3] = {24'h0, if3.out_data};
    assign m_cnt[0]  = {16'h0, if0.trunc_count};
    assign m_cnt[1]  = {16'h0, if1.trunc_count};
    assign m_cnt[2]  = {30'h0, if2.trunc_count};
    assign m_cnt[3]  = {16'h0, if3.trunc_count};
    assign m_valid[0] = if0.out_valid;
    assign m_valid[1] = if1.out_valid;
    assign m_valid[2] = if2.out_valid;
    assign m_valid[3] = if3.out_valid;
    assign m_trunc[0] = if0.out_trunc;
    assign m_trunc[1] = if1.out_trunc;
    assign m_trunc[2] = if2.out_trunc;
    assign m_trunc[3] = if3.out_trunc;
    assign m_rdy[0]  = if0.in_ready;
    assign m_rdy[1]  = if1.in_ready;
    assign m_rdy[2]  = if2.in_ready;
    assign m_rdy[3]  = if3.in_ready;

    task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s dut%0d actual=%h required=%h at %0t", name, k, act, req, $time);
        end
    endtask

    // Reference: value semantics of each variant from plain integer arithmetic.
    function automatic exp_t model(input logic [15:0] w);
        exp_t e;
        int   u;
        int   s;
        u = int'(w);
        s = int'($signed(w));
        e.d[0] = u;
        e.t[0] = 1'b0;
        e.d[1] = s;
        e.t[1] = 1'b0;
        e.d[2] = u % 256;
        e.t[2] = (u > 255);
        e.d[3] = u % 256;
        e.t[3] = (s < -128) || (s > 127);
        return e;
    endfunction

    task automatic drive(input logic v, input logic [15:0] d, input logic r);
        if0.in_valid = v; if0.in_data = d; if0.out_ready = r;
        if1.in_valid = v; if1.in_data = d; if1.out_ready = r;
        if2.in_valid = v; if2.in_data = d; if2.out_ready = r;
        if3.in_valid = v; if3.in_data = d; if3.out_ready = r;
    endtask

    // One clock of stimulus: drive at posedge+1, record an accept at negedge, return at next posedge+1.
    task automatic cycle(input logic v, input logic [15:0] d, input logic r, output logic acc);
        drive(v, d, r);
        @(negedge clk);
        acc = rst_n && v && if0.in_ready;
        if (acc) exp_q.push_back(model(d));
        @(posedge clk);
        #1;
    endtask

    // Monitor: checks handshake flags against an occupancy model, the head word, and the count.
    int          occ = 0;
    int unsigned cmod[4] = '{0, 0, 0, 0};
    int unsigned cmax[4] = '{65535, 65535, 3, 65535};
    always @(negedge clk) begin
        exp_t head;
        logic acc_m;
        logic del_m;
        if (!rst_n) begin
            occ = 0;
            for (int k = 0; k < 4; k++) cmod[k] = 0;
            exp_q.delete();
        end else begin
            for (int k = 0; k < 4; k++) begin
                chk("in_ready", k, {31'h0, m_rdy[k]}, {31'h0, occ < 2});
                chk("out_valid", k, {31'h0, m_valid[k]}, {31'h0, occ > 0});
                chk("trunc_count", k, m_cnt[k], cmod[k]);
            end
            acc_m = if0.in_valid && (occ < 2);
            del_m = if0.out_ready && (occ > 0);
            if (occ > 0) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL scoreboard_empty actual=0 required=nonempty at %0t", $time);
                end else begin
                    head = exp_q[0];
                    for (int k = 0; k < 4; k++) begin
                        chk("out_data", k, m_data[k], head.d[k]);
                        chk("out_trunc", k, {31'h0, m_trunc[k]}, {31'h0, head.t[k]});
                    end
                    if (del_m) begin
                        void'(exp_q.pop_front());
                        for (int k = 0; k < 4; k++)
                            if (head.t[k] && cmod[k] < cmax[k]) cmod[k]++;
                    end
                end
            end
            occ = occ + (acc_m ? 1 : 0) - (del_m ? 1 : 0);
        end
    end

    logic [15:0] directed[6] = '{16'h0000, 16'hFFFF, 16'h7FFF, 16'h0180, 16'hFF80, 16'h0080};
    logic [15:0] specials[6] = '{16'h0000, 16'hFFFF, 16'h007F, 16'hFF80, 16'h0100, 16'h8000};

    initial begin
        logic        acc;
        logic        got;
        logic [15:0] w;
        drive(1'b0, 16'h0, 1'b1);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 0, {31'h0, if0.out_valid}, 32'h0);
        chk("rst_in_ready", 0, {31'h0, if0.in_ready}, 32'h1);
        chk("rst_out_data", 1, if1.out_data, 32'h0);
        chk("rst_out_trunc", 2, {31'h0, if2.out_trunc}, 32'h0);
        chk("rst_trunc_count", 3, {16'h0, if3.trunc_count}, 32'h0);
        rst_n = 1'b1;

        foreach (directed[i]) cycle(1'b1, directed[i], 1'b1, acc);
        repeat (2) cycle(1'b0, 16'h0, 1'b1, acc);

        // Backpressure: A and B fill the buffer, C must be held off until room appears.
        cycle(1'b1, 16'h1234, 1'b0, acc);
        cycle(1'b1, 16'h8765, 1'b0, acc);
        cycle(1'b1, 16'h0042, 1'b0, acc);
        chk("c_held_off", 0, {31'h0, acc}, 32'h0);
        got = 1'b0;
        for (int n = 0; n < 4 && !got; n++) begin
            cycle(1'b1, 16'h0042, 1'b1, acc);
            got = acc;
        end
        chk("c_accepted", 0, {31'h0, got}, 32'h1);
        repeat (3) cycle(1'b0, 16'h0, 1'b1, acc);

        for (int n = 0; n < 400; n++) begin
            w = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 5)] : 16'($urandom);
            cycle($urandom_range(0, 3) != 0, w, $urandom_range(0, 3) != 0, acc);
        end

        // Fill, then reset asynchronously in the middle of a cycle.
        cycle(1'b1, 16'h0180, 1'b0, acc);
        cycle(1'b1, 16'hFF00, 1'b0, acc);
        drive(1'b0, 16'h0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < 4; k++) begin
            chk("midrst_out_valid", k, {31'h0, m_valid[k]}, 32'h0);
            chk("midrst_in_ready", k, {31'h0, m_rdy[k]}, 32'h1);
            chk("midrst_trunc_count", k, m_cnt[k], 32'h0);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) cycle(1'b0, 16'h0, 1'b1, acc);

        for (int n = 0; n < 60; n++) begin
            cycle($urandom_range(0, 1) == 1, 16'($urandom), $urandom_range(0, 3) != 0, acc);
        end
        repeat (4) cycle(1'b0, 16'h0, 1'b1, acc);
        chk("drained", 0, exp_q.size(), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
